// File: rtl/motor_ctrl_pkg.sv
// Shared types and default constants for the motor duty sequencing logic.
package motor_ctrl_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] duty_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_STOP  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam int    PERIOD_DEF           = 350;
  localparam int    RAMP_PERIODS_DEF     = 4;
  localparam duty_t MAX_DUTY_DEF         = 8'd255;
  localparam int    WATCHDOG_PERIODS_DEF = 1024;

endpackage

// File: rtl/motor_period_timer.sv
// Free-running PWM period counter; strobe marks the last clock of each period.
module motor_period_timer
  import motor_ctrl_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic PWMClock,
  input  logic reset_n,
  output logic period_strobe
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge PWMClock or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign period_strobe = (cnt == LAST);

endmodule

// File: rtl/motor_duty_sequencer.sv
// Soft-start / slew-limited duty sequencer with watchdog, brake and latched fault.
module motor_duty_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int    PERIOD           = PERIOD_DEF,
  parameter int    RAMP_PERIODS     = RAMP_PERIODS_DEF,
  parameter duty_t MAX_DUTY         = MAX_DUTY_DEF,
  parameter int    WATCHDOG_PERIODS = WATCHDOG_PERIODS_DEF
) (
  input  logic              PWMClock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              brake,
  input  logic              fault_in,
  input  logic              fault_clear,
  input  logic [DATA_W-1:0] target,
  input  logic              target_valid,
  output logic [DATA_W-1:0] duty_out,
  output logic              motor_on,
  output logic [2:0]        state,
  output logic              fault_latched,
  output logic              period_strobe
);

  localparam int DW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam int WW = $clog2(WATCHDOG_PERIODS) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_PERIODS - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(WATCHDOG_PERIODS);

  function automatic duty_t clamp_duty(duty_t t);
    return (t > MAX_DUTY) ? MAX_DUTY : t;
  endfunction

  function automatic duty_t step_toward(duty_t cur, duty_t tgt);
    if (cur < tgt)      return cur + 1'b1;
    else if (cur > tgt) return cur - 1'b1;
    else                return cur;
  endfunction

  function automatic duty_t dec_sat(duty_t cur);
    return (cur == '0) ? '0 : cur - 1'b1;
  endfunction

  // Reset asserts asynchronously but releases two clocks later, in step with PWMClock.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge PWMClock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  motor_period_timer #(.PERIOD(PERIOD)) u_timer (
    .PWMClock      (PWMClock),
    .reset_n       (rst_n),
    .period_strobe (period_strobe)
  );

  duty_t         target_reg;
  logic [WW-1:0] wd;
  logic          wd_exp;

  assign wd_exp = (wd == WD_MAX);

  always_ff @(posedge PWMClock or negedge rst_n) begin
    if (!rst_n) begin
      target_reg <= '0;
      wd         <= '0;
    end else if (target_valid) begin
      target_reg <= clamp_duty(target);
      wd         <= '0;
    end else if (period_strobe && !wd_exp) begin
      wd <= wd + 1'b1;
    end
  end

  state_t        st, st_n;
  duty_t         duty_n, step_n;
  logic          on_n, flt_n, tick, stop_req;
  logic [DW-1:0] div, div_n;

  always_ff @(posedge PWMClock or negedge rst_n) begin
    if (!rst_n) begin
      st            <= ST_IDLE;
      duty_out      <= '0;
      motor_on      <= 1'b0;
      fault_latched <= 1'b0;
      div           <= '0;
    end else begin
      st            <= st_n;
      duty_out      <= duty_n;
      motor_on      <= on_n;
      fault_latched <= flt_n;
      div           <= div_n;
    end
  end

  // Step arithmetic uses the registered target, so a target arriving on a strobe applies next step.
  always_comb begin
    st_n     = st;
    duty_n   = duty_out;
    on_n     = motor_on;
    flt_n    = fault_latched;
    div_n    = div;
    step_n   = step_toward(duty_out, target_reg);
    stop_req = !enable || wd_exp;
    tick     = period_strobe && (div == DIV_LAST);

    if (fault_in) begin
      st_n   = ST_FAULT;
      duty_n = '0;
      on_n   = 1'b0;
      flt_n  = 1'b1;
    end else begin
      case (st)
        ST_FAULT: begin
          duty_n = '0;
          on_n   = 1'b0;
          if (fault_clear && !enable) begin
            st_n  = ST_IDLE;
            flt_n = 1'b0;
          end
        end
        ST_IDLE: begin
          duty_n = '0;
          on_n   = 1'b0;
          if (enable && !brake && (target_reg != '0) && !wd_exp) begin
            st_n  = ST_RAMP;
            on_n  = 1'b1;
            div_n = '0;
          end
        end
        ST_RAMP: begin
          if (brake) begin
            st_n   = ST_IDLE;
            duty_n = '0;
            on_n   = 1'b0;
          end else if (stop_req) begin
            st_n = ST_STOP;
          end else if (period_strobe) begin
            div_n = tick ? '0 : div + 1'b1;
            if (tick) begin
              duty_n = step_n;
              if (step_n == target_reg) begin
                if (target_reg != '0) st_n = ST_HOLD;
                else begin
                  st_n = ST_IDLE;
                  on_n = 1'b0;
                end
              end
            end
          end
        end
        ST_HOLD: begin
          if (brake) begin
            st_n   = ST_IDLE;
            duty_n = '0;
            on_n   = 1'b0;
          end else if (stop_req) begin
            st_n = ST_STOP;
          end else if (target_reg != duty_out) begin
            st_n  = ST_RAMP;
            div_n = '0;
          end
        end
        ST_STOP: begin
          if (brake) begin
            st_n   = ST_IDLE;
            duty_n = '0;
            on_n   = 1'b0;
          end else if (duty_out == '0) begin
            st_n = ST_IDLE;
            on_n = 1'b0;
          end else if (period_strobe) begin
            duty_n = dec_sat(duty_out);
            if (duty_n == '0) begin
              st_n = ST_IDLE;
              on_n = 1'b0;
            end
          end
        end
        default: begin
          st_n   = ST_IDLE;
          duty_n = '0;
          on_n   = 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_motor_duty_sequencer.sv
// Directed bench for motor_duty_sequencer with a duty-step scoreboard (scaled period/watchdog).
module tb_motor_duty_sequencer;
  import motor_ctrl_pkg::*;

  localparam int    P        = 10;
  localparam int    RP       = 4;
  localparam int    WD       = 16;
  localparam duty_t MAXD     = 8'd90;
  localparam int    STEP_CYC = P * RP;

  logic       PWMClock = 1'b0;
  logic       reset_n = 1'b0, enable = 1'b0, brake = 1'b0;
  logic       fault_in = 1'b0, fault_clear = 1'b0, target_valid = 1'b0;
  logic [7:0] target = 8'd0;
  logic [7:0] duty_out;
  logic       motor_on, fault_latched, period_strobe;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] duty;
    bit         aligned;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] last_duty = 8'd0;
  bit         strobe_prev = 1'b0;
  bit         keepalive = 1'b0;
  logic [7:0] keep_tgt = 8'd0;

  always #5 PWMClock = ~PWMClock;

  motor_duty_sequencer #(
    .PERIOD           (P),
    .RAMP_PERIODS     (RP),
    .MAX_DUTY         (MAXD),
    .WATCHDOG_PERIODS (WD)
  ) dut (
    .PWMClock      (PWMClock),
    .reset_n       (reset_n),
    .enable        (enable),
    .brake         (brake),
    .fault_in      (fault_in),
    .fault_clear   (fault_clear),
    .target        (target),
    .target_valid  (target_valid),
    .duty_out      (duty_out),
    .motor_on      (motor_on),
    .state         (state),
    .fault_latched (fault_latched),
    .period_strobe (period_strobe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge PWMClock);
    #1;
  endtask

  task automatic push_ramp(input int from, input int to, input bit aligned);
    exp_t e;
    e.aligned = aligned;
    if (from <= to) begin
      for (int v = from; v <= to; v++) begin
        e.duty = v[7:0];
        exp_q.push_back(e);
      end
    end else begin
      for (int v = from; v >= to; v--) begin
        e.duty = v[7:0];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic q_empty(input string tag);
    tick();
    check(tag, exp_q.size(), 0);
  endtask

  // Bounded wait on state (on_duty=0) or duty_out (on_duty=1); optionally refreshes the target.
  task automatic wait_for(input bit on_duty, input int val, input int budget,
                          input string tag, output int cyc);
    logic [31:0] cur;
    cyc = 0;
    cur = on_duty ? 32'(duty_out) : 32'(state);
    while (cur != val && cyc < budget) begin
      tick();
      cyc++;
      if (keepalive && (cyc % 50 == 0)) begin
        target       = keep_tgt;
        target_valid = 1'b1;
      end else begin
        target_valid = 1'b0;
      end
      cur = on_duty ? 32'(duty_out) : 32'(state);
    end
    target_valid = 1'b0;
    check({tag, "_reach"}, cur, val);
  endtask

  // Scoreboard: every duty_out change must match the next predicted value.
  always @(negedge PWMClock) begin : monitor
    exp_t e;
    if (!reset_n) begin
      last_duty   = 8'd0;
      strobe_prev = 1'b0;
    end else begin
      if (duty_out !== last_duty) begin
        n_cmp++;
        assert (exp_q.size() > 0)
        else begin
          n_err++;
          $error("FAIL unexpected_step: observed %0d expected no change", duty_out);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("duty_step", duty_out, e.duty);
          if (e.aligned) check("step_after_strobe", strobe_prev, 1);
        end
        last_duty = duty_out;
      end
      strobe_prev = period_strobe;
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: observed no finish expected finish before limit");
    $fatal(1, "time limit");
  end

  initial begin
    int c1, c2, n;

    repeat (3) @(posedge PWMClock);
    #1;
    check("reset_duty", duty_out, 0);
    check("reset_on", motor_on, 0);
    check("reset_state", state, ST_IDLE);
    check("reset_flt", fault_latched, 0);
    reset_n = 1'b1;
    repeat (3) tick();

    c1 = 0;
    while (!period_strobe && c1 < 2 * P) begin tick(); c1++; end
    check("strobe_seen", period_strobe, 1);
    tick();
    c2 = 1;
    while (!period_strobe && c2 < 2 * P) begin tick(); c2++; end
    check("strobe_spacing", c2, P);

    // Soft start 0 -> 10
    enable = 1'b1; target = 8'd10; target_valid = 1'b1;
    push_ramp(1, 10, 1'b1);
    tick(); target_valid = 1'b0;
    tick();
    check("ramp_state", state, ST_RAMP);
    check("ramp_gate", motor_on, 1);
    check("ramp_duty0", duty_out, 0);
    keepalive = 1'b1; keep_tgt = 8'd10;
    wait_for(1'b0, ST_HOLD, 12 * STEP_CYC, "hold10", c1);
    keepalive = 1'b0;
    check_range("ramp10_time", c1 + 2, 39 * P, 41 * P);
    check("hold_duty", duty_out, 10);
    check("hold_gate", motor_on, 1);
    q_empty("q_after_ramp10");

    // Disable -> STOP, decrement per strobe; re-enable does not abort
    enable = 1'b0;
    push_ramp(9, 0, 1'b1);
    tick();
    check("stop_state", state, ST_STOP);
    wait_for(1'b1, 8, 3 * P + 5, "stop_to8", c1);
    enable = 1'b1;
    repeat (3 * P) tick();
    check("stop_keeps", state, ST_STOP);
    check("stop_gate", motor_on, 1);
    enable = 1'b0;
    wait_for(1'b0, ST_IDLE, 12 * P, "stop_idle", c2);
    check_range("stop_time", c1 + 3 * P + c2, 9 * P - 2, 10 * P + 3);
    check("stop_idle_gate", motor_on, 0);
    check("stop_idle_duty", duty_out, 0);
    q_empty("q_after_stop");

    // Reset mid-ramp at 37
    enable = 1'b1; target = 8'd50; target_valid = 1'b1;
    push_ramp(1, 37, 1'b1);
    tick(); target_valid = 1'b0;
    keepalive = 1'b1; keep_tgt = 8'd50;
    wait_for(1'b1, 37, 40 * STEP_CYC, "ramp37", c1);
    keepalive = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("rst_duty", duty_out, 0);
    check("rst_on", motor_on, 0);
    check("rst_state", state, ST_IDLE);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    check("post_rst_state", state, ST_IDLE);
    check("post_rst_duty", duty_out, 0);
    check("post_rst_on", motor_on, 0);
    q_empty("q_after_reset");

    // Fault during RAMP at 50
    target = 8'd60; target_valid = 1'b1;
    push_ramp(1, 50, 1'b1);
    tick(); target_valid = 1'b0;
    keepalive = 1'b1; keep_tgt = 8'd60;
    wait_for(1'b1, 50, 52 * STEP_CYC, "ramp50", c1);
    keepalive = 1'b0;
    tick();
    check("pre_fault_state", state, ST_RAMP);
    fault_in = 1'b1;
    push_ramp(0, 0, 1'b0);
    tick(); fault_in = 1'b0;
    check("flt_state", state, ST_FAULT);
    check("flt_duty", duty_out, 0);
    check("flt_on", motor_on, 0);
    check("flt_latched", fault_latched, 1);
    fault_clear = 1'b1;
    tick(); fault_clear = 1'b0;
    tick();
    check("clr_ignored_state", state, ST_FAULT);
    check("clr_ignored_flt", fault_latched, 1);
    enable = 1'b0; fault_clear = 1'b1;
    tick(); fault_clear = 1'b0;
    check("clr_state", state, ST_IDLE);
    check("clr_flt", fault_latched, 0);
    q_empty("q_after_fault");

    // Clamp to MAX_DUTY, then watchdog expiry in HOLD
    enable = 1'b1; target = 8'd250; target_valid = 1'b1;
    push_ramp(1, 90, 1'b1);
    tick(); target_valid = 1'b0;
    keepalive = 1'b1; keep_tgt = 8'd250;
    wait_for(1'b0, ST_HOLD, 95 * STEP_CYC, "hold_clamp", c1);
    keepalive = 1'b0;
    check("hold_clamp_duty", duty_out, 90);
    target = 8'd250; target_valid = 1'b1;
    tick(); target_valid = 1'b0;
    wait_for(1'b0, ST_STOP, 20 * P, "wd_stop", c1);
    check_range("wd_time", c1 + 1, 15 * P, 16 * P + 3);
    push_ramp(89, 0, 1'b1);
    wait_for(1'b0, ST_IDLE, 95 * P, "wd_idle", c2);
    check("wd_idle_on", motor_on, 0);
    check("wd_idle_duty", duty_out, 0);
    repeat (3 * P) tick();
    check("wd_blocks_restart", state, ST_IDLE);
    q_empty("q_after_wd");

    // New target restarts ramp from 0
    target = 8'd20; target_valid = 1'b1;
    push_ramp(1, 12, 1'b1);
    tick(); target_valid = 1'b0;
    tick();
    check("restart_state", state, ST_RAMP);
    check("restart_duty", duty_out, 0);
    keepalive = 1'b1; keep_tgt = 8'd20;
    wait_for(1'b1, 12, 14 * STEP_CYC, "ramp12", c1);
    keepalive = 1'b0;

    // New target on the exact step strobe: that step still uses the old target
    n = 0; c2 = 0;
    while (c2 < 6 * P) begin
      if (period_strobe) begin
        n++;
        if (n == RP) break;
      end
      tick();
      c2++;
    end
    check("coinc_found", n, RP);
    target = 8'd5; target_valid = 1'b1;
    push_ramp(13, 13, 1'b1);
    push_ramp(12, 5, 1'b1);
    tick(); target_valid = 1'b0;
    keepalive = 1'b1; keep_tgt = 8'd5;
    wait_for(1'b0, ST_HOLD, 10 * STEP_CYC, "hold5", c1);
    keepalive = 1'b0;
    check("hold5_duty", duty_out, 5);

    // Brake outranks disable: straight to IDLE, no ramp down
    push_ramp(0, 0, 1'b0);
    brake = 1'b1; enable = 1'b0;
    tick(); brake = 1'b0;
    check("brake_state", state, ST_IDLE);
    check("brake_duty", duty_out, 0);
    check("brake_on", motor_on, 0);
    repeat (5) tick();
    check("brake_stays", state, ST_IDLE);
    q_empty("q_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
